// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: request/acknowledge data-memory access with stall, timeout abort and MEM/WB register.
// Optional misaligned-access exception is enabled by defining LSU_MISALIGN_EXC_EN.
module mem_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pass_data,
  input  logic [4:0]  rd,
  input  logic        regwrite,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        addr_exc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    lat_size;
  logic          lat_uns;
  logic [1:0]    lat_off;
  logic [4:0]    lat_rd;
  logic          lat_regwrite;

  logic        mem_op;
  logic        misaligned;
  logic        abort;
  logic [3:0]  be_calc;
  logic [31:0] wdata_lanes;
  logic [31:0] load_data;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign mem_op = mem_valid & (mem_read | mem_write);

`ifdef LSU_MISALIGN_EXC_EN
  logic addr_exc_q;
  assign misaligned = ((mem_size == 2'b01) & addr[0]) | (mem_size[1] & (addr[1:0] != 2'b00));
  assign addr_exc   = addr_exc_q;
`else
  assign misaligned = 1'b0;
  assign addr_exc   = 1'b0;
`endif

  assign abort = (state == S_WAIT) & ~dm_ack & (cnt == CW'(TIMEOUT - 1));
  assign stall = ((state == S_IDLE) & mem_op & ~misaligned) |
                 ((state == S_WAIT) & ~dm_ack & ~abort);

  // Lane steering for stores; offending low bits of half/word addresses are ignored here.
  always_comb begin
    be_calc     = 4'b1111;
    wdata_lanes = wdata;
    case (mem_size)
      2'b00: begin
        be_calc     = 4'b0001 << addr[1:0];
        wdata_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc     = 4'b0011 << {addr[1], 1'b0};
        wdata_lanes = {2{wdata[15:0]}};
      end
      default: begin
        be_calc     = 4'b1111;
        wdata_lanes = wdata;
      end
    endcase
  end

  always_comb begin
    byte_lane = dm_rdata[7:0];
    case (lat_off)
      2'b00:   byte_lane = dm_rdata[7:0];
      2'b01:   byte_lane = dm_rdata[15:8];
      2'b10:   byte_lane = dm_rdata[23:16];
      default: byte_lane = dm_rdata[31:24];
    endcase
    half_lane = lat_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (lat_size)
      2'b00:   load_data = lat_uns ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   load_data = lat_uns ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_data = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_be        <= '0;
      dm_wdata     <= '0;
      lat_size     <= '0;
      lat_uns      <= 1'b0;
      lat_off      <= '0;
      lat_rd       <= '0;
      lat_regwrite <= 1'b0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      bus_err      <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
      addr_exc_q   <= 1'b0;
`endif
    end else begin
      bus_err <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
      addr_exc_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (mem_op && !misaligned) begin
            state        <= S_WAIT;
            cnt          <= '0;
            dm_req       <= 1'b1;
            dm_we        <= mem_write;
            dm_addr      <= {addr[31:2], 2'b00};
            dm_be        <= mem_write ? be_calc : 4'b0000;
            dm_wdata     <= wdata_lanes;
            lat_size     <= mem_size;
            lat_uns      <= mem_unsigned;
            lat_off      <= addr[1:0];
            lat_rd       <= rd;
            lat_regwrite <= regwrite;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
          end else if (mem_valid) begin
            wb_valid    <= 1'b1;
            wb_regwrite <= regwrite & ~mem_op;
            wb_rd       <= rd;
            wb_data     <= pass_data;
`ifdef LSU_MISALIGN_EXC_EN
            addr_exc_q  <= mem_op;
`endif
          end else begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
          end
        end
        S_WAIT: begin
          if (dm_ack) begin
            state       <= S_IDLE;
            dm_req      <= 1'b0;
            wb_valid    <= 1'b1;
            wb_regwrite <= lat_regwrite & ~dm_we;
            wb_rd       <= lat_rd;
            if (!dm_we) wb_data <= load_data;
          end else if (abort) begin
            state       <= S_IDLE;
            dm_req      <= 1'b0;
            wb_valid    <= 1'b1;
            wb_regwrite <= 1'b0;
            wb_rd       <= lat_rd;
            bus_err     <= 1'b1;
          end else begin
            cnt         <= cnt + 1'b1;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu; expected values are hand-computed per scenario.
// Build with LSU_MISALIGN_EXC_EN defined to exercise the misaligned-exception variant.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_read, mem_write, mem_unsigned, regwrite;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata, pass_data;
  logic [4:0]  rd;
  logic        stall, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        wb_valid, wb_regwrite, bus_err, addr_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  // Values observed by run_access for the test tasks to compare.
  int          obs_stall_cnt;
  logic        obs_req, obs_we, obs_ack_stall;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_wb_valid, obs_wb_regwrite;
  logic [4:0]  obs_wb_rd;
  logic [31:0] obs_wb_data;

  mem_lsu #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr),
    .wdata(wdata), .pass_data(pass_data), .rd(rd), .regwrite(regwrite),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .bus_err(bus_err), .addr_exc(addr_exc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b10;
    mem_unsigned = 1'b0; addr = '0; wdata = '0; pass_data = '0; rd = '0;
    regwrite = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
  endtask

  // Drives one memory op, waits 'waits' un-acked WAIT cycles, then acks with 'rdata'.
  task automatic run_access(input logic r, input logic w, input logic [1:0] size,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdata, input logic [4:0] dst, input int waits);
    mem_valid = 1'b1; mem_read = r; mem_write = w; mem_size = size; mem_unsigned = uns;
    addr = a; wdata = wd; rd = dst; regwrite = r; pass_data = 32'hCAFE_0000;
    #1;
    obs_stall_cnt = stall ? 1 : 0;
    tick();
    obs_req = dm_req; obs_we = dm_we; obs_addr = dm_addr; obs_be = dm_be; obs_wdata = dm_wdata;
    for (int i = 0; i < waits; i++) begin
      obs_stall_cnt += stall ? 1 : 0;
      tick();
    end
    dm_ack = 1'b1; dm_rdata = rdata;
    #1;
    obs_ack_stall = stall;
    obs_stall_cnt += stall ? 1 : 0;
    tick();
    idle_inputs();
    obs_wb_valid = wb_valid; obs_wb_regwrite = wb_regwrite;
    obs_wb_rd = wb_rd; obs_wb_data = wb_data;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++; if (dm_req !== 1'b0) begin errors++; $display("[TB] FAIL reset dm_req: got %b expected 0", dm_req); end
    checks++; if ({wb_valid, wb_regwrite, bus_err, addr_exc, dm_we} !== 5'b0) begin errors++; $display("[TB] FAIL reset flags: got %b expected 00000", {wb_valid, wb_regwrite, bus_err, addr_exc, dm_we}); end
    checks++; if ({wb_data, dm_addr, dm_wdata, wb_rd, dm_be} !== '0) begin errors++; $display("[TB] FAIL reset data: got %h %h %h %h %h expected zeros", wb_data, dm_addr, dm_wdata, wb_rd, dm_be); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset stall: got %b expected 0", stall); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    mem_valid = 1'b1; pass_data = 32'h0000_1234; rd = 5'd5; regwrite = 1'b1;
    dm_ack = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL pass stall: got %b expected 0", stall); end
    tick();
    checks++; if ({wb_valid, wb_regwrite} !== 2'b11) begin errors++; $display("[TB] FAIL pass wb flags: got %b expected 11", {wb_valid, wb_regwrite}); end
    checks++; if (wb_data !== 32'h0000_1234) begin errors++; $display("[TB] FAIL pass wb_data: got %h expected 00001234", wb_data); end
    checks++; if (wb_rd !== 5'd5) begin errors++; $display("[TB] FAIL pass wb_rd: got %0d expected 5", wb_rd); end
    checks++; if (dm_req !== 1'b0) begin errors++; $display("[TB] FAIL pass dm_req: got %b expected 0", dm_req); end
    idle_inputs();
    tick();
    checks++; if ({wb_valid, wb_regwrite} !== 2'b00) begin errors++; $display("[TB] FAIL bubble wb flags: got %b expected 00", {wb_valid, wb_regwrite}); end
  endtask

  task automatic test_load_byte();
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, '0, 32'h80FF_FFFF, 5'd7, 0);
    checks++; if (obs_req !== 1'b1) begin errors++; $display("[TB] FAIL lb dm_req: got %b expected 1", obs_req); end
    checks++; if (obs_addr !== 32'h0000_0100) begin errors++; $display("[TB] FAIL lb dm_addr: got %h expected 00000100", obs_addr); end
    checks++; if ({obs_we, obs_be} !== 5'b0_0000) begin errors++; $display("[TB] FAIL lb we/be: got %b expected 00000", {obs_we, obs_be}); end
    checks++; if (obs_stall_cnt !== 1) begin errors++; $display("[TB] FAIL lb stall cycles: got %0d expected 1", obs_stall_cnt); end
    checks++; if (obs_wb_data !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL lb wb_data: got %h expected ffffff80", obs_wb_data); end
    checks++; if ({obs_wb_valid, obs_wb_regwrite, obs_wb_rd} !== {2'b11, 5'd7}) begin errors++; $display("[TB] FAIL lb wb fields: got %b %0d expected 11 7", {obs_wb_valid, obs_wb_regwrite}, obs_wb_rd); end
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, '0, 32'h80FF_FFFF, 5'd7, 0);
    checks++; if (obs_wb_data !== 32'h0000_0080) begin errors++; $display("[TB] FAIL lbu wb_data: got %h expected 00000080", obs_wb_data); end
  endtask

  task automatic test_load_half();
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0042, '0, 32'h80FF_1234, 5'd9, 1);
    checks++; if (obs_wb_data !== 32'hFFFF_80FF) begin errors++; $display("[TB] FAIL lh wb_data: got %h expected ffff80ff", obs_wb_data); end
    run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0040, '0, 32'h80FF_9234, 5'd9, 0);
    checks++; if (obs_wb_data !== 32'h0000_9234) begin errors++; $display("[TB] FAIL lhu wb_data: got %h expected 00009234", obs_wb_data); end
  endtask

  task automatic test_store_half();
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 5'd3, 3);
    checks++; if (obs_we !== 1'b1) begin errors++; $display("[TB] FAIL sh dm_we: got %b expected 1", obs_we); end
    checks++; if (obs_be !== 4'b1100) begin errors++; $display("[TB] FAIL sh dm_be: got %b expected 1100", obs_be); end
    checks++; if (obs_wdata !== 32'hABCD_ABCD) begin errors++; $display("[TB] FAIL sh dm_wdata: got %h expected abcdabcd", obs_wdata); end
    checks++; if (obs_addr !== 32'h0000_0200) begin errors++; $display("[TB] FAIL sh dm_addr: got %h expected 00000200", obs_addr); end
    checks++; if (obs_stall_cnt !== 4) begin errors++; $display("[TB] FAIL sh stall cycles: got %0d expected 4", obs_stall_cnt); end
    checks++; if (obs_ack_stall !== 1'b0) begin errors++; $display("[TB] FAIL sh ack stall: got %b expected 0", obs_ack_stall); end
    checks++; if ({obs_wb_valid, obs_wb_regwrite} !== 2'b10) begin errors++; $display("[TB] FAIL sh wb flags: got %b expected 10", {obs_wb_valid, obs_wb_regwrite}); end
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_005A, '0, 5'd3, 0);
    checks++; if ({obs_be, obs_wdata} !== {4'b0010, 32'h5A5A_5A5A}) begin errors++; $display("[TB] FAIL sb be/wdata: got %b %h expected 0010 5a5a5a5a", obs_be, obs_wdata); end
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, '0, 5'd3, 0);
    checks++; if ({obs_be, obs_wdata} !== {4'b1111, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL sw be/wdata: got %b %h expected 1111 deadbeef", obs_be, obs_wdata); end
  endtask

  task automatic test_timeout();
    int req_cnt;
    req_cnt = 0;
    mem_valid = 1'b1; mem_read = 1'b1; mem_size = 2'b10; addr = 32'h0000_0010; rd = 5'd4; regwrite = 1'b1;
    tick();
    for (int i = 1; i <= 16; i++) begin
      req_cnt += dm_req ? 1 : 0;
      checks++; if (stall !== (i != 16)) begin errors++; $display("[TB] FAIL timeout stall cycle %0d: got %b expected %b", i, stall, (i != 16)); end
      tick();
    end
    idle_inputs();
    checks++; if (req_cnt !== 16) begin errors++; $display("[TB] FAIL timeout req cycles: got %0d expected 16", req_cnt); end
    checks++; if ({dm_req, bus_err, wb_valid, wb_regwrite} !== 4'b0110) begin errors++; $display("[TB] FAIL timeout abort: got %b expected 0110", {dm_req, bus_err, wb_valid, wb_regwrite}); end
    tick();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout bus_err pulse: got %b expected 0", bus_err); end
    mem_valid = 1'b1; pass_data = 32'h0000_0077; rd = 5'd2; regwrite = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL timeout back in idle stall: got %b expected 0", stall); end
    tick();
    idle_inputs();
    checks++; if (wb_data !== 32'h0000_0077) begin errors++; $display("[TB] FAIL timeout next op wb_data: got %h expected 00000077", wb_data); end
  endtask

  task automatic test_misaligned();
`ifdef LSU_MISALIGN_EXC_EN
    mem_valid = 1'b1; mem_read = 1'b1; mem_size = 2'b10; addr = 32'h0000_0006; rd = 5'd8; regwrite = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL misalign stall: got %b expected 0", stall); end
    tick();
    idle_inputs();
    checks++; if ({dm_req, addr_exc, wb_valid, wb_regwrite} !== 4'b0110) begin errors++; $display("[TB] FAIL misalign exc: got %b expected 0110", {dm_req, addr_exc, wb_valid, wb_regwrite}); end
    tick();
    checks++; if ({dm_req, addr_exc} !== 2'b00) begin errors++; $display("[TB] FAIL misalign pulse: got %b expected 00", {dm_req, addr_exc}); end
`else
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, '0, 32'hDEAD_BEEF, 5'd8, 0);
    checks++; if ({obs_req, obs_addr} !== {1'b1, 32'h0000_0004}) begin errors++; $display("[TB] FAIL misalign req/addr: got %b %h expected 1 00000004", obs_req, obs_addr); end
    checks++; if (obs_wb_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL misalign wb_data: got %h expected deadbeef", obs_wb_data); end
    checks++; if (addr_exc !== 1'b0) begin errors++; $display("[TB] FAIL misalign addr_exc: got %b expected 0", addr_exc); end
`endif
  endtask

  task automatic test_reset_in_wait();
    mem_valid = 1'b1; mem_read = 1'b1; mem_size = 2'b10; addr = 32'h0000_0020; rd = 5'd6; regwrite = 1'b1;
    tick();
    tick();
    checks++; if (dm_req !== 1'b1) begin errors++; $display("[TB] FAIL rst wait dm_req before: got %b expected 1", dm_req); end
    rst_n = 1'b0;
    #1;
    checks++; if ({dm_req, wb_valid} !== 2'b00) begin errors++; $display("[TB] FAIL rst wait drop: got %b expected 00", {dm_req, wb_valid}); end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst wait no wb: got %b expected 0", wb_valid); end
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0024, '0, 32'h1357_9BDF, 5'd6, 0);
    checks++; if ({obs_stall_cnt, obs_wb_data} !== {32'd1, 32'h1357_9BDF}) begin errors++; $display("[TB] FAIL rst wait next op: got %0d %h expected 1 13579bdf", obs_stall_cnt, obs_wb_data); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_byte();
    test_load_half();
    test_store_half();
    test_timeout();
    test_misaligned();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
